// File: rtl/memorio_bus_pkg.sv
// ----------------------------------------------------------------------------
// memorio_bus_pkg
//   Shared definitions for the memory/IO stage: the IO window prefix, the
//   word offsets of the IO registers, CTRL bit positions and the address
//   decoder used by the load mux and the register write enables.
// ----------------------------------------------------------------------------
package memorio_bus_pkg;

    // Addr_result[31:10] all ones selects the IO window.
    localparam logic [21:0] IO_PREFIX  = 22'h3FFFFF;

    localparam logic [9:0]  OFF_SWITCH = 10'h000;
    localparam logic [9:0]  OFF_LED    = 10'h004;
    localparam logic [9:0]  OFF_CNT    = 10'h008;
    localparam logic [9:0]  OFF_CTRL   = 10'h00C;

    localparam int CTRL_CLR_BIT = 0;
    localparam int CTRL_EN_BIT  = 1;

    typedef enum logic [1:0] {
        IO_SWITCH = 2'd0,
        IO_LED    = 2'd1,
        IO_CNT    = 2'd2,
        IO_CTRL   = 2'd3
    } io_reg_e;

    typedef struct packed {
        logic    hit;   // address names a mapped IO register
        io_reg_e sel;   // which register (only meaningful when hit=1)
    } io_dec_t;

    // Byte lanes Addr_result[1:0] are ignored: decode on the word offset only.
    function automatic io_dec_t io_decode(input logic [31:0] addr);
        io_dec_t d;
        d.hit = 1'b0;
        d.sel = IO_SWITCH;
        if (addr[31:10] == IO_PREFIX) begin
            case ({addr[9:2], 2'b00})
                OFF_SWITCH: begin d.hit = 1'b1; d.sel = IO_SWITCH; end
                OFF_LED:    begin d.hit = 1'b1; d.sel = IO_LED;    end
                OFF_CNT:    begin d.hit = 1'b1; d.sel = IO_CNT;    end
                OFF_CTRL:   begin d.hit = 1'b1; d.sel = IO_CTRL;   end
                default:    ;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/memorio_bus_sw_debounce.sv
// ----------------------------------------------------------------------------
// memorio_bus_sw_debounce
//   Two-flop synchronizer followed by a whole-vector debouncer. A new
//   synchronized value must stay unchanged for DEB_CYCLES clocks before it
//   replaces the stable value; any change before that restarts the count.
// Ports
//   i_clk        in   1     clock, rising edge
//   i_rst        in   1     asynchronous active-high reset
//   i_sw         in   SW_W  raw asynchronous switch pins
//   o_sw_stable  out  SW_W  debounced switch value
// ----------------------------------------------------------------------------
module memorio_bus_sw_debounce #(
    parameter int SW_W       = 24,
    parameter int DEB_CYCLES = 20
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [SW_W-1:0] i_sw,
    output logic [SW_W-1:0] o_sw_stable
);

    localparam int            DW       = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [SW_W-1:0] r_sync0;
    logic [SW_W-1:0] r_sync1;    // sw_sync
    logic [SW_W-1:0] r_stable;
    logic [DW-1:0]   r_deb_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync0   <= '0;
            r_sync1   <= '0;
            r_stable  <= '0;
            r_deb_cnt <= '0;
        end else begin
            r_sync0 <= i_sw;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_stable  <= r_sync1;
                r_deb_cnt <= '0;
            end else if (r_sync0 != r_sync1) begin
                // sw_sync takes a new value on this edge, so its stability
                // count starts again from zero.
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    assign o_sw_stable = r_stable;

endmodule

// File: rtl/memorio_bus.sv
// ----------------------------------------------------------------------------
// memorio_bus
//   Data-side memory/IO stage of the single-cycle CPU. Loads and stores go
//   either to data memory or to a small IO register file (debounced switches,
//   LED register, free-running cycle counter, counter control).
// Ports
//   clock, reset          clock (rising edge), async active-high reset
//   MemRead/MemWrite      data memory strobes from control32
//   IORead/IOWrite        IO window strobes from control32
//   Addr_result, Wdata    ALU byte address and store data
//   Mem_rdata             data memory read data
//   Mem_addr/Mem_wdata    pass-through address / store data to data memory
//   Mem_we                data memory write enable, blocked during IO writes
//   Rdata                 combinational load data to write-back
//   switch_i, led_o       raw switch pins, registered LED pins
// ----------------------------------------------------------------------------
module memorio_bus
    import memorio_bus_pkg::*;
#(
    parameter int SW_W       = 24,
    parameter int LED_W      = 24,
    parameter int DEB_CYCLES = 20,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             IORead,
    input  logic             IOWrite,
    input  logic [31:0]      Addr_result,
    input  logic [31:0]      Wdata,
    input  logic [31:0]      Mem_rdata,
    output logic [31:0]      Mem_addr,
    output logic [31:0]      Mem_wdata,
    output logic             Mem_we,
    output logic [31:0]      Rdata,
    input  logic [SW_W-1:0]  switch_i,
    output logic [LED_W-1:0] led_o
);

    logic [SW_W-1:0]  w_sw_stable;
    io_dec_t          w_io_dec;
    logic             w_led_wr;
    logic             w_ctrl_wr;
    logic [31:0]      w_io_rdata;

    logic [LED_W-1:0] r_led;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_en;

    memorio_bus_sw_debounce #(
        .SW_W       (SW_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) sw_debounce (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_sw        (switch_i),
        .o_sw_stable (w_sw_stable)
    );

    assign Mem_addr  = Addr_result;
    assign Mem_wdata = Wdata;
    assign Mem_we    = MemWrite & ~IOWrite;

    assign w_io_dec  = io_decode(Addr_result);
    assign w_led_wr  = IOWrite & w_io_dec.hit & (w_io_dec.sel == IO_LED);
    assign w_ctrl_wr = IOWrite & w_io_dec.hit & (w_io_dec.sel == IO_CTRL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_led_wr) begin
            r_led <= Wdata[LED_W-1:0];
        end
    end

    // The enable used for this edge's increment is the old one; a clear in
    // the same CTRL write overrides the increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_cnt_en <= 1'b1;
        end else begin
            if (w_ctrl_wr) begin
                r_cnt_en <= Wdata[CTRL_EN_BIT];
            end
            if (w_ctrl_wr && Wdata[CTRL_CLR_BIT]) begin
                r_cnt <= '0;
            end else if (r_cnt_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign led_o = r_led;

    // CTRL is write-only and reads as zero, like unmapped offsets.
    always_comb begin
        w_io_rdata = '0;
        if (w_io_dec.hit) begin
            case (w_io_dec.sel)
                IO_SWITCH: w_io_rdata = 32'(w_sw_stable);
                IO_LED:    w_io_rdata = 32'(r_led);
                IO_CNT:    w_io_rdata = 32'(r_cnt);
                default:   w_io_rdata = '0;
            endcase
        end
    end

    assign Rdata = IORead  ? w_io_rdata :
                   MemRead ? Mem_rdata  : 32'd0;

endmodule

// File: tb/tb_memorio_bus.sv
// ----------------------------------------------------------------------------
// tb_memorio_bus
//   Directed bench for memorio_bus. A second instance with an 8-bit counter
//   shares all inputs so counter wrap-around can be reached in a few hundred
//   cycles. Inputs change on the falling edge; outputs are sampled shortly
//   after it.
// ----------------------------------------------------------------------------
module tb_memorio_bus;

  localparam logic [31:0] A_SW   = 32'hFFFF_FC00;
  localparam logic [31:0] A_LED  = 32'hFFFF_FC04;
  localparam logic [31:0] A_CNT  = 32'hFFFF_FC08;
  localparam logic [31:0] A_CTRL = 32'hFFFF_FC0C;
  localparam logic [31:0] A_UNM  = 32'hFFFF_FC40;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        mem_read, mem_write, io_read_s, io_write_s;
  logic [31:0] addr_result, wdata, mem_rdata;
  logic [23:0] switch_i;

  logic [31:0] mem_addr, mem_wdata, rdata;
  logic        mem_we;
  logic [23:0] led_o;

  logic [31:0] mem_addr_c8, mem_wdata_c8, rdata_c8;
  logic        mem_we_c8;
  logic [23:0] led_o_c8;

  memorio_bus dut (
    .clock       (clock),
    .reset       (reset),
    .MemRead     (mem_read),
    .MemWrite    (mem_write),
    .IORead      (io_read_s),
    .IOWrite     (io_write_s),
    .Addr_result (addr_result),
    .Wdata       (wdata),
    .Mem_rdata   (mem_rdata),
    .Mem_addr    (mem_addr),
    .Mem_wdata   (mem_wdata),
    .Mem_we      (mem_we),
    .Rdata       (rdata),
    .switch_i    (switch_i),
    .led_o       (led_o)
  );

  memorio_bus #(.CNT_W(8)) dut_c8 (
    .clock       (clock),
    .reset       (reset),
    .MemRead     (mem_read),
    .MemWrite    (mem_write),
    .IORead      (io_read_s),
    .IOWrite     (io_write_s),
    .Addr_result (addr_result),
    .Wdata       (wdata),
    .Mem_rdata   (mem_rdata),
    .Mem_addr    (mem_addr_c8),
    .Mem_wdata   (mem_wdata_c8),
    .Mem_we      (mem_we_c8),
    .Rdata       (rdata_c8),
    .switch_i    (switch_i),
    .led_o       (led_o_c8)
  );

  // scoreboard counters and checker
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    io_read_s   = 1'b0;
    io_write_s  = 1'b0;
    addr_result = 32'h0;
    wdata       = 32'h0;
  endtask

  // One rising edge with IOWrite high; returns on the following falling edge.
  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    io_write_s  = 1'b1;
    addr_result = a;
    wdata       = d;
    @(negedge clock);
    io_write_s  = 1'b0;
  endtask

  task automatic io_rd(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d8);
    io_read_s   = 1'b1;
    addr_result = a;
    #1;
    d  = rdata;
    d8 = rdata_c8;
    io_read_s   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, r8, acc;
    idle();
    switch_i  = 24'h0;
    mem_rdata = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // power-on state
    io_rd(A_CNT, r, r8);
    chk("por_cnt", r, 32'h0);
    chk("por_led", {8'h0, led_o}, 32'h0);
    io_rd(A_SW, r, r8);
    chk("por_sw", r, 32'h0);

    // 1: reset mid-run clears LED and counter without a clock edge
    io_write(A_LED, 32'h00AB_CDEF);
    chk("led_pre", {8'h0, led_o}, 32'h00AB_CDEF);
    io_write(A_CTRL, 32'h3);
    repeat (8'h55) @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("cnt_55", r, 32'h55);
    chk("cnt8_55", r8, 32'h55);
    reset = 1'b1;
    #1;
    chk("rst_led_async", {8'h0, led_o}, 32'h0);
    io_rd(A_CNT, r, r8);
    chk("rst_cnt_async", r, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("rst_cnt_en", r, 32'h1);

    // 2: LED write with a concurrent MemWrite; Mem_we blocked
    io_write_s  = 1'b1;
    mem_write   = 1'b1;
    addr_result = A_LED;
    wdata       = 32'h1234_5678;
    #1;
    chk("io_we_block", {31'h0, mem_we}, 32'h0);
    chk("led_before_edge", {8'h0, led_o}, 32'h0);
    @(negedge clock);
    idle();
    chk("led_write", {8'h0, led_o}, 32'h0034_5678);
    io_rd(A_LED, r, r8);
    chk("led_read", r, 32'h0034_5678);

    // 3a: 5-cycle glitch never appears
    @(negedge clock);
    switch_i = 24'h000001;
    repeat (5) @(negedge clock);
    switch_i = 24'h0;
    acc = 32'h0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      io_rd(A_SW, r, r8);
      acc = acc | r;
    end
    chk("sw_glitch", acc, 32'h0);

    // 3b: clean change becomes visible after exactly 22 edges
    switch_i = 24'h00000F;
    acc = 32'h0;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clock);
      io_rd(A_SW, r, r8);
      if (n < 22) acc = acc | r;
      if (n == 22) chk("sw_clean_22", r, 32'h0000_000F);
    end
    chk("sw_clean_1_21", acc, 32'h0);

    // 3c: intermediate value restarts the count
    switch_i = 24'h000003;
    repeat (15) @(negedge clock);
    switch_i = 24'h000007;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clock);
      io_rd(A_SW, r, r8);
      if (n == 21) chk("sw_restart_21", r, 32'h0000_000F);
      if (n == 22) chk("sw_restart_22", r, 32'h0000_0007);
    end

    // 4: counter clear, enable, freeze, wrap
    io_write(A_CTRL, 32'h3);
    repeat (100) @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("cnt_100", r, 32'd100);
    io_write(A_CTRL, 32'h3);
    io_rd(A_CNT, r, r8);
    chk("cnt_clr0", r, 32'h0);
    @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("cnt_clr1", r, 32'h1);
    @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("cnt_clr2", r, 32'h2);
    io_write(A_CTRL, 32'h0);
    io_rd(A_CNT, r, r8);
    chk("cnt_stop_edge", r, 32'h3);
    repeat (5) @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("cnt_frozen", r, 32'h3);
    io_write(A_CTRL, 32'h3);
    repeat (255) @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("cnt_255", r, 32'hFF);
    chk("cnt8_max", r8, 32'hFF);
    @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("cnt_256", r, 32'h100);
    chk("cnt8_wrap", r8, 32'h0);

    // 5: data memory path and read priority
    @(negedge clock);
    mem_read    = 1'b1;
    addr_result = 32'h0000_0010;
    mem_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("mem_rdata", rdata, 32'hDEAD_BEEF);
    chk("mem_addr", mem_addr, 32'h0000_0010);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    wdata     = 32'hCAFE_F00D;
    #1;
    chk("mem_we", {31'h0, mem_we}, 32'h1);
    chk("mem_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_write = 1'b0;
    #1;
    chk("mem_we_off", {31'h0, mem_we}, 32'h0);
    chk("rdata_none", rdata, 32'h0);
    @(negedge clock);
    mem_read    = 1'b1;
    io_read_s   = 1'b1;
    addr_result = A_LED;
    #1;
    chk("io_beats_mem", rdata, 32'h0034_5678);
    idle();

    // 6: unmapped IO offset
    @(negedge clock);
    io_rd(A_UNM, r, r8);
    chk("unm_read", r, 32'h0);
    io_write(A_CTRL, 32'h3);
    io_write(A_UNM, 32'hFFFF_FFFD);
    chk("unm_led", {8'h0, led_o}, 32'h0034_5678);
    io_rd(A_CNT, r, r8);
    chk("unm_cnt", r, 32'h1);
    @(negedge clock);
    io_rd(A_CNT, r, r8);
    chk("unm_cnt_en", r, 32'h2);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
